// File: rtl/program_loader.sv
// UART-fed program loader: receives a length-prefixed little-endian image
// and writes it word by word into the core's instruction memory.
module program_loader #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 10,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_req,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [DataWidth-1:0] program_in,
    output logic [AddrWidth-1:0] address_in,
    output logic                 prog_we,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int NB = DataWidth / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = AddrWidth + 1;
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [16:0] MaxLen = 17'(2 ** AddrWidth);

    typedef enum logic [2:0] {
        RUN, LEN0, LEN1, WORD, WRITE, FINISH, ERR
    } state_e;

    state_e                 state_q;
    logic [15:0]            len_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [TW-1:0]          timer_q;
    logic [DataWidth-1:0]   word_q;
    logic [DataWidth-1:0]   word_d;
    logic [DataWidth-1:0]   data_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [16:0]            cnt_nxt;
    logic [16:0]            len_new;
    logic                   timeout;

    always_comb begin
        word_d = word_q;
        word_d[{idx_q, 3'b000} +: 8] = rx_data;
    end

    assign cnt_nxt = 17'(cnt_q) + 17'd1;
    assign len_new = {1'b0, rx_data, len_q[7:0]};
    assign timeout = (timer_q == TW'(TimeoutCycles - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            word_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                RUN, ERR: begin
                    if (load_req) begin
                        state_q <= LEN0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        timer_q <= '0;
                    end
                end
                LEN0: begin
                    if (rx_valid) begin
                        len_q[7:0] <= rx_data;
                        timer_q    <= '0;
                        state_q    <= LEN1;
                    end else if (timeout) begin
                        state_q <= ERR;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LEN1: begin
                    if (rx_valid) begin
                        len_q[15:8] <= rx_data;
                        timer_q     <= '0;
                        idx_q       <= '0;
                        if (len_new == 17'd0)
                            state_q <= FINISH;
                        else if (len_new > MaxLen)
                            state_q <= ERR;
                        else
                            state_q <= WORD;
                    end else if (timeout) begin
                        state_q <= ERR;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WORD: begin
                    if (rx_valid) begin
                        word_q  <= word_d;
                        timer_q <= '0;
                        if (idx_q == IW'(NB - 1)) begin
                            // Capture now so prog_we and data line up in WRITE.
                            data_q  <= word_d;
                            addr_q  <= cnt_q[AddrWidth-1:0];
                            idx_q   <= '0;
                            state_q <= WRITE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timeout) begin
                        state_q <= ERR;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WRITE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_nxt == {1'b0, len_q})
                        state_q <= FINISH;
                    else
                        state_q <= WORD;
                end
                FINISH: state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign program_in = data_q;
    assign address_in = addr_q;
    assign prog_we    = (state_q == WRITE);
    assign done       = (state_q == FINISH);
    assign error      = (state_q == ERR);
    assign core_reset = (state_q != RUN);
    assign busy       = state_q inside {LEN0, LEN1, WORD, WRITE, FINISH};

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DataWidth, default 32, instruction word width.
REQ-002 SHALL have parameter AddrWidth, default 10, instruction memory word-address width.
REQ-003 SHALL have parameter TimeoutCycles, default 1000000, idle-byte timeout in clocks.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 load_req  input  1  single-cycle pulse requesting a new program load.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data holds a received byte.
REQ-008 rx_data  input  8  received byte.
REQ-009 program_in  output  DataWidth  instruction word to core instruction memory.
REQ-010 address_in  output  AddrWidth  word address for program_in.
REQ-011 prog_we  output  1  instruction memory write enable.
REQ-012 core_reset  output  1  holds core in reset while high.
REQ-013 busy  output  1  high in any loading state.
REQ-014 done  output  1  one-cycle pulse on successful load completion.
REQ-015 error  output  1  sticky load-failure flag.

Function
REQ-016 SHALL implement states RUN, LEN0, LEN1, WORD, WRITE, FINISH, ERR.
REQ-017 RUN: core_reset=0, busy=0; load_req -> LEN0, clear error, clear word counter and byte index.
REQ-018 LEN0/LEN1: accept byte on rx_valid into length[7:0] then length[15:8] (little-endian); LEN0 -> LEN1 on byte.
REQ-019 LEN1 on byte: length==0 -> FINISH; length > 2^AddrWidth -> ERR; else -> WORD.
REQ-020 WORD: accept bytes little-endian into assembly register (byte 0 -> bits 7:0 ... byte 3 -> bits 31:24); after 4th byte -> WRITE.
REQ-021 WRITE: exactly one cycle; prog_we=1, program_in=assembled word, address_in=word counter; then counter+1; counter==length -> FINISH else -> WORD with byte index 0.
REQ-022 rx_valid in WRITE or FINISH SHALL be ignored (byte dropped, no error); senders space bytes >=2 clocks.
REQ-023 FINISH: one cycle, done=1, then -> RUN (core_reset drops the cycle after done).
REQ-024 core_reset=1 and busy=1 in LEN0, LEN1, WORD, WRITE, FINISH; core_reset=1, busy=0 in ERR.
REQ-025 Timeout counter SHALL clear on every accepted byte and on state entry into LEN0; reaching TimeoutCycles in LEN0/LEN1/WORD -> ERR.
REQ-026 ERR: error=1 (held), core_reset=1; only load_req leaves ERR (-> LEN0, error cleared).
REQ-027 load_req in any state other than RUN or ERR SHALL be ignored.
REQ-028 prog_we SHALL be 0 outside WRITE; program_in/address_in hold last written values outside WRITE.
REQ-029 word counter width AddrWidth+1; address_in = counter[AddrWidth-1:0]; length 2^AddrWidth writes addresses 0..2^AddrWidth-1 without wrap.
REQ-030 Latency: prog_we asserts the cycle after the 4th byte of each word is accepted.

Reset
REQ-031 Reset assertion SHALL immediately force RUN, core_reset=0, busy=0, done=0, error=0, prog_we=0, program_in=0, address_in=0, counters=0, independent of clock.
REQ-032 Reset mid-load SHALL abandon the load; no further prog_we until a new load_req after reset release.

Verification
REQ-033 load_req; bytes 02 00, 13 05 10 00, 93 05 20 00 -> prog_we at addr 0 data 0x00100513, addr 1 data 0x00200593, done pulse, core_reset 1 -> 0.
REQ-034 load_req; bytes 00 00 -> no prog_we, done pulse one cycle after 2nd byte, error=0.
REQ-035 load_req; bytes 01 05 (length 1281 > 1024) -> ERR, error=1, core_reset=1, no prog_we; later load_req clears error.
REQ-036 TimeoutCycles=16; load_req; bytes 01 00 13 05, then silence -> ERR after 16 idle clocks, no prog_we.
REQ-037 load_req; length 3, reset asserted after 2nd word -> outputs at reset values asynchronously; post-release bytes cause no writes.
REQ-038 load_req repeated while in WORD -> ignored; load completes with correct addresses and single done.
